// File: rtl/pe_ctrl_sequencer.sv
// Per-PE control sequencer: drives MACC enable/op_code and buffer read/write strobes
// for accumulate passes, or streams the buffer out for flush passes, on a packed ctrl bus.
module pe_ctrl_sequencer #(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH         = 16,
  parameter int WB_LATENCY        = 3,
  localparam int CTRL_WIDTH       = 10 + 2 * PE_BUF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_macc_count,
  input  logic [CNT_WIDTH-1:0]  cfg_num_out,
  input  logic                  cfg_first_pass,
  input  logic                  cfg_flush,
  input  logic [2:0]            cfg_op_code,
  input  logic                  operand_valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  src_2_sel,
  output logic                  busy,
  output logic                  done
);

  localparam int AW                = PE_BUF_ADDR_WIDTH;
  localparam int unsigned ADDR_SPAN = 1 << PE_BUF_ADDR_WIDTH;
  localparam logic SRC_2_BIAS      = 1'b1;
  localparam logic SRC_2_BUF       = 1'b0;
  localparam logic KIND_WRITE      = 1'b0;
  localparam logic KIND_FLUSH      = 1'b1;

  localparam int B_EN     = 3;
  localparam int B_RD     = 4;
  localparam int B_WR     = 5;
  localparam int B_WV     = 6;
  localparam int B_FLUSH  = 7;
  localparam int B_WADDR  = 8;
  localparam int B_RADDR  = 8 + AW;
  localparam int B_POP    = 8 + 2 * AW;
  localparam int B_PUSH   = 9 + 2 * AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MACC,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_mac_idx;
  logic [CNT_WIDTH-1:0]  r_out_idx;
  logic [CNT_WIDTH-1:0]  r_mac_cnt;
  logic [CNT_WIDTH-1:0]  r_num_out;
  logic                  r_first_pass;
  logic [2:0]            r_op_code;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic                  r_src_2_sel;
  logic                  r_busy;
  logic                  r_done;
  logic [WB_LATENCY-1:0] r_pipe_vld;
  logic [WB_LATENCY-1:0] r_pipe_kind;
  logic [AW-1:0]         r_pipe_addr [WB_LATENCY];

  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  w_cfg_count;
  logic [CNT_WIDTH-1:0]  w_cfg_num;
  state_t                w_eff_state;
  logic [CNT_WIDTH-1:0]  w_eff_mac_idx;
  logic [CNT_WIDTH-1:0]  w_eff_out_idx;
  logic [CNT_WIDTH-1:0]  w_eff_count;
  logic [CNT_WIDTH-1:0]  w_eff_num;
  logic                  w_eff_first;
  logic [2:0]            w_eff_op;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  w_next_mac;
  logic [CNT_WIDTH-1:0]  w_next_out;
  logic                  w_enable;
  logic                  w_read;
  logic                  w_flush;
  logic [2:0]            w_op;
  logic [AW-1:0]         w_rd_addr;
  logic                  w_push;
  logic                  w_push_kind;
  logic [AW-1:0]         w_push_addr;
  logic                  w_pipe_wr;
  logic                  w_pipe_wv;
  logic [CTRL_WIDTH-1:0] w_ctrl_next;

  // Config sanitising: zero MAC count means one cycle; oversize pass lengths fold into the buffer.
  always_comb begin
    w_cfg_count = (cfg_macc_count == '0) ? CNT_WIDTH'(1) : cfg_macc_count;
    w_cfg_num   = cfg_num_out;
    if ((AW < CNT_WIDTH) && (cfg_num_out > CNT_WIDTH'(ADDR_SPAN)))
      w_cfg_num = cfg_num_out & CNT_WIDTH'(ADDR_SPAN - 1);
  end

  // An accepted start behaves as the first cycle of the pass so its strobe is registered
  // on the same edge, making the first MACC/FLUSH action visible one cycle after start.
  always_comb begin
    w_accept = (r_state == S_IDLE) && start;
    if (w_accept) begin
      if (w_cfg_num == '0)  w_eff_state = S_IDLE;
      else if (cfg_flush)   w_eff_state = S_FLUSH;
      else                  w_eff_state = S_MACC;
      w_eff_mac_idx = '0;
      w_eff_out_idx = '0;
      w_eff_count   = w_cfg_count;
      w_eff_num     = w_cfg_num;
      w_eff_first   = cfg_first_pass;
      w_eff_op      = cfg_op_code;
    end else begin
      w_eff_state   = r_state;
      w_eff_mac_idx = r_mac_idx;
      w_eff_out_idx = r_out_idx;
      w_eff_count   = r_mac_cnt;
      w_eff_num     = r_num_out;
      w_eff_first   = r_first_pass;
      w_eff_op      = r_op_code;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_mac   = w_eff_mac_idx;
    w_next_out   = w_eff_out_idx;
    w_enable     = 1'b0;
    w_read       = 1'b0;
    w_flush      = 1'b0;
    w_op         = 3'd0;
    w_rd_addr    = '0;
    w_push       = 1'b0;
    w_push_kind  = KIND_WRITE;
    w_push_addr  = '0;
    case (w_eff_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_DONE;
      end
      S_MACC: begin
        w_next_state = S_MACC;
        if (operand_valid) begin
          w_enable = 1'b1;
          w_op     = w_eff_op;
          if ((w_eff_mac_idx == '0) && !w_eff_first) begin
            w_read    = 1'b1;
            w_rd_addr = AW'(w_eff_out_idx);
          end
          if (w_eff_mac_idx == (w_eff_count - CNT_WIDTH'(1))) begin
            w_push      = 1'b1;
            w_push_kind = KIND_WRITE;
            w_push_addr = AW'(w_eff_out_idx);
            w_next_mac  = '0;
            if (w_eff_out_idx == (w_eff_num - CNT_WIDTH'(1)))
              w_next_state = S_DRAIN;
            else
              w_next_out = w_eff_out_idx + CNT_WIDTH'(1);
          end else begin
            w_next_mac = w_eff_mac_idx + CNT_WIDTH'(1);
          end
        end
      end
      S_FLUSH: begin
        w_next_state = S_FLUSH;
        w_read       = 1'b1;
        w_flush      = 1'b1;
        w_rd_addr    = AW'(w_eff_out_idx);
        w_push       = 1'b1;
        w_push_kind  = KIND_FLUSH;
        w_push_addr  = AW'(w_eff_out_idx);
        if (w_eff_out_idx == (w_eff_num - CNT_WIDTH'(1)))
          w_next_state = S_DRAIN;
        else
          w_next_out = w_eff_out_idx + CNT_WIDTH'(1);
      end
      S_DRAIN: begin
        if (r_pipe_vld == '0) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Write-back side of the bus comes from the oldest delay-line slot.
  always_comb begin
    w_pipe_wr   = r_pipe_vld[WB_LATENCY-1] && (r_pipe_kind[WB_LATENCY-1] == KIND_WRITE);
    w_pipe_wv   = r_pipe_vld[WB_LATENCY-1] && (r_pipe_kind[WB_LATENCY-1] == KIND_FLUSH);
    w_ctrl_next = '0;
    w_ctrl_next[2:0]          = w_op;
    w_ctrl_next[B_EN]         = w_enable;
    w_ctrl_next[B_RD]         = w_read;
    w_ctrl_next[B_WR]         = w_pipe_wr;
    w_ctrl_next[B_WV]         = w_pipe_wv;
    w_ctrl_next[B_FLUSH]      = w_flush;
    w_ctrl_next[B_WADDR +: AW] = w_pipe_wr ? r_pipe_addr[WB_LATENCY-1] : '0;
    w_ctrl_next[B_RADDR +: AW] = w_rd_addr;
    w_ctrl_next[B_POP]        = 1'b0;
    w_ctrl_next[B_PUSH]       = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mac_idx    <= '0;
      r_out_idx    <= '0;
      r_mac_cnt    <= '0;
      r_num_out    <= '0;
      r_first_pass <= 1'b0;
      r_op_code    <= 3'd0;
      r_ctrl       <= '0;
      r_src_2_sel  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pipe_vld   <= '0;
      r_pipe_kind  <= '0;
      for (int i = 0; i < WB_LATENCY; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_state   <= w_next_state;
      r_mac_idx <= w_next_mac;
      r_out_idx <= w_next_out;
      if (w_accept) begin
        r_mac_cnt    <= w_cfg_count;
        r_num_out    <= w_cfg_num;
        r_first_pass <= cfg_first_pass;
        r_op_code    <= cfg_op_code;
        r_src_2_sel  <= cfg_first_pass ? SRC_2_BIAS : SRC_2_BUF;
      end
      for (int i = WB_LATENCY - 1; i > 0; i--) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_kind[i] <= r_pipe_kind[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
      r_pipe_vld[0]  <= w_push;
      r_pipe_kind[0] <= w_push_kind;
      r_pipe_addr[0] <= w_push_addr;
      r_ctrl <= w_ctrl_next;
      r_busy <= (w_next_state != S_IDLE);
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign ctrl      = r_ctrl;
  assign src_2_sel = r_src_2_sel;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Bench for pe_ctrl_sequencer: directed passes from the pass timing rules plus randomized
// passes, each compared cycle by cycle against a beat-level reference model.
module tb_pe_ctrl_sequencer;
  localparam int AW    = 10;
  localparam int CW    = 16;
  localparam int L     = 3;
  localparam int CTRLW = 10 + 2 * AW;
  localparam int MAXC  = 400;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CW-1:0]    cfg_macc_count = '0;
  logic [CW-1:0]    cfg_num_out = '0;
  logic             cfg_first_pass = 1'b0;
  logic             cfg_flush = 1'b0;
  logic [2:0]       cfg_op_code = 3'd0;
  logic             operand_valid = 1'b0;
  logic [CTRLW-1:0] ctrl;
  logic             src_2_sel;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [CTRLW-1:0] exp_ctrl [MAXC];
  bit               vseq [MAXC];
  int               exp_done;

  always #5 clk = ~clk;

  pe_ctrl_sequencer #(
    .PE_BUF_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .WB_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_macc_count(cfg_macc_count),
    .cfg_num_out(cfg_num_out),
    .cfg_first_pass(cfg_first_pass),
    .cfg_flush(cfg_flush),
    .cfg_op_code(cfg_op_code),
    .operand_valid(operand_valid),
    .ctrl(ctrl),
    .src_2_sel(src_2_sel),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // vseq[c] is the operand_valid that governs the strobes seen in cycle c.
  task automatic fill_valid(input int stall_pct);
    for (int c = 0; c < MAXC; c++)
      vseq[c] = (c > 100) || (int'($urandom_range(99)) >= stall_pct);
  endtask

  // Reference: the k-th valid beat of the pass is MAC k%count of address k/count.
  task automatic build_model(input int count, input int num, input bit first,
                             input bit flush, input logic [2:0] op);
    int cnt;
    int k;
    int last_ev;
    cnt     = (count == 0) ? 1 : count;
    k       = 0;
    last_ev = 0;
    for (int c = 0; c < MAXC; c++) exp_ctrl[c] = '0;
    if (num == 0) begin
      exp_done = 1;
    end else if (flush) begin
      for (int a = 0; a < num; a++) begin
        exp_ctrl[1 + a][7]           = 1'b1;
        exp_ctrl[1 + a][4]           = 1'b1;
        exp_ctrl[1 + a][8 + AW +: AW] = AW'(a);
        exp_ctrl[1 + a + L][6]       = 1'b1;
      end
      exp_done = num + L + 1;
    end else begin
      for (int c = 1; (c < MAXC - L - 2) && (k < cnt * num); c++) begin
        if (vseq[c]) begin
          exp_ctrl[c][3]   = 1'b1;
          exp_ctrl[c][2:0] = op;
          if ((k % cnt == 0) && !first) begin
            exp_ctrl[c][4]            = 1'b1;
            exp_ctrl[c][8 + AW +: AW] = AW'(k / cnt);
          end
          if (k % cnt == cnt - 1) begin
            exp_ctrl[c + L][5]       = 1'b1;
            exp_ctrl[c + L][8 +: AW] = AW'(k / cnt);
            last_ev = c + L;
          end
          k++;
        end
      end
      exp_done = last_ev + 1;
    end
  endtask

  // Entered and left at a negedge of an idle cycle, so passes chain with start
  // driven in the very cycle busy has fallen.
  task automatic run_pass(input int count, input int num, input bit first, input bit flush,
                          input logic [2:0] op, input bit junk, input int plan_done);
    int obs_done;
    obs_done = 0;
    build_model(count, num, first, flush, op);
    start          = 1'b1;
    cfg_macc_count = CW'(count);
    cfg_num_out    = CW'(num);
    cfg_first_pass = first;
    cfg_flush      = flush;
    cfg_op_code    = op;
    operand_valid  = vseq[1];
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      chk("ctrl", 64'(ctrl), 64'(exp_ctrl[c]));
      chk("busy", 64'(busy), 64'(c <= exp_done));
      chk("done", 64'(done), 64'(c == exp_done));
      if (c <= exp_done) chk("src_2_sel", 64'(src_2_sel), 64'(first));
      if (done && obs_done == 0) obs_done = c;
      operand_valid = vseq[c + 1];
      if (junk && c <= exp_done) begin
        start          = 1'($urandom_range(1));
        cfg_macc_count = CW'($urandom);
        cfg_num_out    = CW'($urandom);
        cfg_first_pass = 1'($urandom_range(1));
        cfg_flush      = 1'($urandom_range(1));
        cfg_op_code    = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (plan_done > 0) chk("plan_done_cycle", 64'(obs_done), 64'(plan_done));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, 64'(ctrl), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_src_2_sel", 64'(src_2_sel), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    fill_valid(0); run_pass(3, 2, 1'b1, 1'b0, 3'd1, 1'b0, 10);
    fill_valid(0); run_pass(3, 2, 1'b0, 1'b0, 3'd1, 1'b0, 10);
    fill_valid(0); vseq[2] = 1'b0;
    run_pass(2, 1, 1'b0, 1'b0, 3'd5, 1'b0, 7);
    fill_valid(0); run_pass(0, 4, 1'b0, 1'b1, 3'd0, 1'b0, 8);
    fill_valid(0); run_pass(2, 0, 1'b1, 1'b0, 3'd2, 1'b0, 1);
    fill_valid(0); run_pass(3, 2, 1'b0, 1'b0, 3'd1, 1'b1, 10);
    fill_valid(0); run_pass(0, 3, 1'b0, 1'b0, 3'd7, 1'b0, 7);

    for (int p = 0; p < 40; p++) begin
      fill_valid(30);
      run_pass(int'($urandom_range(4)), int'($urandom_range(5)), 1'($urandom_range(1)),
               ($urandom_range(3) == 0), 3'($urandom), 1'b1, 0);
    end

    // Abort a pass with write-backs still queued.
    start = 1'b1; cfg_macc_count = CW'(1); cfg_num_out = CW'(3);
    cfg_first_pass = 1'b1; cfg_flush = 1'b0; cfg_op_code = 3'd4; operand_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_quiet("abort");
    chk("abort_src_2_sel", 64'(src_2_sel), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk_quiet("post_abort");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
